hex_display_ctrl: RTL and testbench

Registered, parametrised multi-digit driver for the DE1-SoC seven-segment displays. It supersedes per-switch direct decoding: it latches a hex word on a load strobe and drives up to six active-low HEX digits in static, blink, scroll or hold mode, paced by an internal prescaler. It is intended as the shared display back-end for the store/UPC datapaths.

---
 rtl/hex_display_ctrl_if.sv | 22 ++
 rtl/hex_display_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_ctrl_if.sv
// Bus bundle for hex_display_ctrl: load strobe, hex word, mode select,
// leading-zero blank request, plus the segment and tick outputs.
interface hex_display_ctrl_if #(
   parameter int NUM_DIGITS = 6
) ();
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   data_in;
   logic [1:0]                mode;
   logic                      blank_lz;
   logic [7*NUM_DIGITS-1:0]   hex_out;
   logic                      tick_out;

   modport master (
      output load, data_in, mode, blank_lz,
      input  hex_out, tick_out
   );

   modport slave (
      input  load, data_in, mode, blank_lz,
      output hex_out, tick_out
   );
endinterface

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: registered multi-digit seven-segment driver for the
// DE1-SoC HEX displays. Latches a hex word on load and shows it in static,
// blink, scroll or hold mode, paced by an internal prescaler tick.
// Optional build macro: HEX_LZ_BLANK_EN enables leading-zero suppression
// (gated by blank_lz); without it blank_lz is ignored.
module hex_display_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 25_000_000
) (
   input logic               clk,
   input logic               reset,
   hex_display_ctrl_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int OW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;
   localparam int HW = 7 * NUM_DIGITS;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [OW-1:0] OFF_MAX   = OW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_SCROLL = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   logic [DW-1:0] data_r, data_n;
   logic [PW-1:0] presc, presc_n;
   logic [OW-1:0] offset, offset_n;
   logic          phase, phase_n;
   logic [HW-1:0] hex_r, hex_n;
   logic          tick_r, tick_n;
   mode_t         mode_q, mode_c;
   logic          tick;
   logic          entering;
   logic [NUM_DIGITS-1:0] lz_mask;

   // Active-low glyphs, segment a on bit 0 through g on bit 6.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

`ifdef HEX_LZ_BLANK_EN
   // Digit i (i>0) is a leading zero when it and every higher nibble are zero.
   always_comb begin
      logic zero_above;
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
         zero_above = zero_above & (data_r[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
         lz_mask[NUM_DIGITS-1-k] = zero_above & bus.blank_lz;
      end
   end
`else
   logic blank_lz_unused;
   assign blank_lz_unused = bus.blank_lz;
   assign lz_mask = '0;
`endif

   // Next-state for prescaler, data, offset, phase and the display register.
   always_comb begin
      mode_c   = mode_t'(bus.mode);
      entering = (mode_c != mode_q);
      tick     = (presc == PRESC_MAX);
      data_n   = data_r;
      presc_n  = tick ? '0 : presc + 1'b1;
      offset_n = offset;
      phase_n  = phase;
      hex_n    = hex_r;
      tick_n   = tick & ~bus.load;

      // Outside scroll offset is held at 0 and outside blink phase at 1, which
      // covers the "force on entry" rule; hold alone freezes once entered.
      case (mode_c)
         MODE_STATIC: begin
            offset_n = '0;
            phase_n  = 1'b1;
         end
         MODE_BLINK: begin
            offset_n = '0;
            if (tick) phase_n = ~phase;
         end
         MODE_SCROLL: begin
            phase_n = 1'b1;
            if (tick) offset_n = (offset == OFF_MAX) ? '0 : offset + 1'b1;
         end
         default: begin
            if (entering) begin
               offset_n = '0;
               phase_n  = 1'b1;
            end
         end
      endcase

      if (bus.load) begin
         data_n   = bus.data_in;
         presc_n  = '0;
         offset_n = '0;
         phase_n  = 1'b1;
      end

      if (mode_c != MODE_HOLD) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            int unsigned src;
            logic [6:0]  seg;
            src = i;
            if (mode_c == MODE_SCROLL) begin
               src = i + NUM_DIGITS - int'(offset);
               if (src >= NUM_DIGITS) src = src - NUM_DIGITS;
            end
            seg = glyph(data_r[4*src +: 4]);
            if ((mode_c != MODE_SCROLL) && lz_mask[i]) seg = '1;
            if ((mode_c == MODE_BLINK) && !phase) seg = '1;
            hex_n[7*i +: 7] = seg;
         end
      end
   end

   // State register; reset wins over load, tick and mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r <= '0;
         presc  <= '0;
         offset <= '0;
         phase  <= 1'b1;
         hex_r  <= '1;
         tick_r <= 1'b0;
         mode_q <= MODE_STATIC;
      end else begin
         data_r <= data_n;
         presc  <= presc_n;
         offset <= offset_n;
         phase  <= phase_n;
         hex_r  <= hex_n;
         tick_r <= tick_n;
         mode_q <= mode_c;
      end
   end

   assign bus.hex_out  = hex_r;
   assign bus.tick_out = tick_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (NUM_DIGITS=6, TICK_DIV=4).
module tb_hex_display_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [41:0] exp_hex;

   hex_display_ctrl_if #(.NUM_DIGITS(6)) bus ();

   hex_display_ctrl #(.NUM_DIGITS(6), .TICK_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [23:0] v);
      bus.load    = 1'b1;
      bus.data_in = v;
      step(1);
      bus.load    = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step(3);
      checks++;
      if (bus.hex_out !== {42{1'b1}}) begin
         errors++;
         $display("FAIL reset_hex: got %h expected %h", bus.hex_out, {42{1'b1}});
      end
      checks++;
      if (bus.tick_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b expected 0", bus.tick_out);
      end
      reset = 1'b0;
      step(2);
      exp_hex = {6{7'h40}};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL reset_release_zero: got %h expected %h", bus.hex_out, exp_hex);
      end
   endtask

   task automatic test_static;
      bus.mode = 2'b00;
      do_load(24'h12AB0F);
      step(1);
      exp_hex = {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL static_12AB0F: got %h expected %h", bus.hex_out, exp_hex);
      end
      do_load(24'h345678);
      step(1);
      exp_hex = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL static_345678: got %h expected %h", bus.hex_out, exp_hex);
      end
      do_load(24'h9CDE00);
      step(1);
      exp_hex = {7'h10, 7'h46, 7'h21, 7'h06, 7'h40, 7'h40};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL static_9CDE00: got %h expected %h", bus.hex_out, exp_hex);
      end
   endtask

   task automatic test_leading_zeros;
      bus.mode     = 2'b00;
      bus.blank_lz = 1'b1;
      do_load(24'h000A05);
      step(1);
`ifdef HEX_LZ_BLANK_EN
      exp_hex = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12};
`else
      exp_hex = {7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12};
`endif
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL lz_000A05: got %h expected %h", bus.hex_out, exp_hex);
      end
      do_load(24'h000000);
      step(1);
`ifdef HEX_LZ_BLANK_EN
      exp_hex = {{5{7'h7F}}, 7'h40};
`else
      exp_hex = {6{7'h40}};
`endif
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL lz_all_zero: got %h expected %h", bus.hex_out, exp_hex);
      end
      bus.blank_lz = 1'b0;
   endtask

   task automatic test_blink;
      logic [41:0] shown;
      shown = {{5{7'h40}}, 7'h79};
      bus.mode = 2'b01;
      do_load(24'h000001);
      step(1);
      checks++;
      if (bus.hex_out !== shown) begin
         errors++;
         $display("FAIL blink_on_first: got %h expected %h", bus.hex_out, shown);
      end
      step(3);
      checks++;
      if (bus.tick_out !== 1'b1) begin
         errors++;
         $display("FAIL blink_tick1: got %b expected 1", bus.tick_out);
      end
      step(1);
      checks++;
      if (bus.hex_out !== {42{1'b1}}) begin
         errors++;
         $display("FAIL blink_off: got %h expected %h", bus.hex_out, {42{1'b1}});
      end
      checks++;
      if (bus.tick_out !== 1'b0) begin
         errors++;
         $display("FAIL blink_tick_width: got %b expected 0", bus.tick_out);
      end
      step(3);
      checks++;
      if (bus.tick_out !== 1'b1) begin
         errors++;
         $display("FAIL blink_tick2: got %b expected 1", bus.tick_out);
      end
      step(1);
      checks++;
      if (bus.hex_out !== shown) begin
         errors++;
         $display("FAIL blink_on_again: got %h expected %h", bus.hex_out, shown);
      end
   endtask

   task automatic test_scroll;
      bus.mode = 2'b10;
      do_load(24'h123456);
      step(1);
      exp_hex = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL scroll_start: got %h expected %h", bus.hex_out, exp_hex);
      end
      step(4);
      exp_hex = {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h79};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL scroll_1tick: got %h expected %h", bus.hex_out, exp_hex);
      end
      step(4);
      exp_hex = {7'h30, 7'h19, 7'h12, 7'h02, 7'h79, 7'h24};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL scroll_2tick: got %h expected %h", bus.hex_out, exp_hex);
      end
      step(16);
      exp_hex = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL scroll_wrap6: got %h expected %h", bus.hex_out, exp_hex);
      end
      step(4);
      do_load(24'h123456);
      step(1);
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL scroll_reload: got %h expected %h", bus.hex_out, exp_hex);
      end
   endtask

   task automatic test_load_tick_same_cycle;
      // Prescaler is at 1 here; two more edges bring it to the wrap value.
      step(2);
      do_load(24'h654321);
      step(1);
      exp_hex = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL load_tick_offset0: got %h expected %h", bus.hex_out, exp_hex);
      end
      step(4);
      exp_hex = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h02};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL load_tick_presc_cleared: got %h expected %h", bus.hex_out, exp_hex);
      end
   endtask

   task automatic test_hold;
      bus.mode = 2'b00;
      do_load(24'h123456);
      step(1);
      exp_hex = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
      bus.mode = 2'b11;
      step(1);
      do_load(24'hFFFFFF);
      step(6);
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL hold_frozen: got %h expected %h", bus.hex_out, exp_hex);
      end
      bus.mode = 2'b00;
      step(1);
      exp_hex = {6{7'h0E}};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL hold_exit: got %h expected %h", bus.hex_out, exp_hex);
      end
   endtask

   task automatic test_reset_mid_scroll;
      bus.mode = 2'b10;
      do_load(24'h123456);
      step(5);
      exp_hex = {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h79};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL midreset_pre: got %h expected %h", bus.hex_out, exp_hex);
      end
      reset = 1'b1;
      step(1);
      checks++;
      if (bus.hex_out !== {42{1'b1}}) begin
         errors++;
         $display("FAIL midreset_hex: got %h expected %h", bus.hex_out, {42{1'b1}});
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.tick_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tick cycle %0d: got %b expected 0", k, bus.tick_out);
         end
         step(1);
      end
      reset    = 1'b0;
      bus.mode = 2'b00;
      step(2);
      exp_hex = {6{7'h40}};
      checks++;
      if (bus.hex_out !== exp_hex) begin
         errors++;
         $display("FAIL midreset_cleared: got %h expected %h", bus.hex_out, exp_hex);
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.load     = 1'b0;
      bus.data_in  = '0;
      bus.mode     = 2'b00;
      bus.blank_lz = 1'b0;
      test_reset;
      test_static;
      test_leading_zeros;
      test_blink;
      test_scroll;
      test_load_tick_same_cycle;
      test_hold;
      test_reset_mid_scroll;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
